// File: rtl/regfile_port_arbiter.sv
// Arbiter for register-file port A: WB writeback, ID rs read and debug register reads.
// A debug read steals the port for one stalled cycle, immediately if the pipeline is frozen.
module regfile_port_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        PCLK,
    input  logic        RST,
    input  logic        pipe_run,
    input  logic [3:0]  id_ra1,
    output logic [15:0] id_rd1,
    input  logic        wb_we,
    input  logic [3:0]  wb_wa,
    input  logic [15:0] wb_wd,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_ra,
    output logic        dbg_grant,
    output logic [15:0] dbg_rd,
    output logic [3:0]  rf_a1,
    output logic        rf_we,
    output logic [15:0] rf_wd,
    input  logic [15:0] rf_rd1,
    output logic        stall,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READ  = 2'd2,
        GRANT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       ra_q;

    // Port A mux; a WB write blocked in READ re-issues after the stall releases MEMWB
    always_comb begin
        rf_a1 = id_ra1;
        rf_we = 1'b0;
        if (state == READ) begin
            rf_a1 = ra_q;
        end else if (wb_we) begin
            rf_a1 = wb_wa;
            rf_we = 1'b1;
        end
    end

    assign rf_wd  = wb_wd;
    assign id_rd1 = rf_rd1;

    // stall and dbg_grant are loaded with the decode of the next state
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ra_q         <= 4'd0;
            dbg_grant    <= 1'b0;
            dbg_rd       <= 16'd0;
            stall        <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;

            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        ra_q     <= dbg_ra;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!dbg_req) begin
                        state <= IDLE;
                    end else if (!pipe_run || (wait_cnt == CNT_W'(MAX_WAIT))) begin
                        state <= READ;
                        stall <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    dbg_rd <= rf_rd1;
                    stall  <= 1'b0;
                    if (dbg_req) begin
                        state     <= GRANT;
                        dbg_grant <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!dbg_req) begin
                        state     <= IDLE;
                        dbg_grant <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    stall     <= 1'b0;
                    dbg_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 16x16 register file on port A.
module tb_regfile_port_arbiter;

    logic        PCLK = 1'b0;
    logic        RST;
    logic        pipe_run;
    logic [3:0]  id_ra1;
    logic [15:0] id_rd1;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [15:0] wb_wd;
    logic        dbg_req;
    logic [3:0]  dbg_ra;
    logic        dbg_grant;
    logic [15:0] dbg_rd;
    logic [3:0]  rf_a1;
    logic        rf_we;
    logic [15:0] rf_wd;
    logic [15:0] rf_rd1;
    logic        stall;
    logic [15:0] stall_cycles;
    logic        mem_clr;

    logic [15:0] rf_mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PCLK = ~PCLK;

    regfile_port_arbiter #(.MAX_WAIT(8), .CNT_W(4)) dut (
        .PCLK(PCLK), .RST(RST), .pipe_run(pipe_run),
        .id_ra1(id_ra1), .id_rd1(id_rd1),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .dbg_req(dbg_req), .dbg_ra(dbg_ra), .dbg_grant(dbg_grant), .dbg_rd(dbg_rd),
        .rf_a1(rf_a1), .rf_we(rf_we), .rf_wd(rf_wd), .rf_rd1(rf_rd1),
        .stall(stall), .stall_cycles(stall_cycles)
    );

    // Register file model: async read, write on posedge
    always @(posedge PCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'd0;
        end else if (rf_we) begin
            rf_mem[rf_a1] <= rf_wd;
        end
    end
    assign rf_rd1 = rf_mem[rf_a1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
        wb_we = 1'b1;
        wb_wa = a;
        wb_wd = d;
        #1;
        check("wb_pass_we", rf_we, 1'b1);
        check("wb_pass_a1", rf_a1, a);
        tick();
        wb_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        RST = 1'b1; pipe_run = 1'b0; id_ra1 = 4'd7;
        wb_we = 1'b0; wb_wa = 4'd0; wb_wd = 16'd0;
        dbg_req = 1'b0; dbg_ra = 4'd0; mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        do_reset();

        // Reset state
        check("rst_grant", dbg_grant, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_scnt", stall_cycles, 16'd0);
        check("rst_dbg_rd", dbg_rd, 16'd0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_a1", rf_a1, 4'd7);

        wb_write(4'd5, 16'h1234);
        wb_write(4'd3, 16'hBEEF);
        wb_write(4'd1, 16'h1111);
        wb_write(4'd2, 16'h2222);

        // Paused read of R5; dbg_ra changes after IDLE are ignored
        pipe_run = 1'b0; dbg_ra = 4'd5; dbg_req = 1'b1;
        tick();
        dbg_ra = 4'd9;
        check("p_wait_stall", stall, 1'b0);
        check("p_wait_grant", dbg_grant, 1'b0);
        tick();
        check("p_read_stall", stall, 1'b1);
        check("p_read_we", rf_we, 1'b0);
        check("p_read_a1", rf_a1, 4'd5);
        tick();
        check("p_grant", dbg_grant, 1'b1);
        check("p_grant_stall", stall, 1'b0);
        check("p_dbg_rd", dbg_rd, 16'h1234);
        check("p_scnt", stall_cycles, 16'd1);
        dbg_req = 1'b0;
        tick();
        check("p_release", dbg_grant, 1'b0);

        // Running read with forced stall plus WB write collision on R3
        do_reset();
        check("rst2_dbg_rd", dbg_rd, 16'd0);
        pipe_run = 1'b1; dbg_ra = 4'd3; dbg_req = 1'b1;
        tick();
        n = 1;
        while (!stall && n < 30) begin
            tick();
            n++;
        end
        check("r_read_cycle", n, 10);
        wb_we = 1'b1; wb_wa = 4'd3; wb_wd = 16'h00AA;
        #1;
        check("r_read_we", rf_we, 1'b0);
        check("r_read_a1", rf_a1, 4'd3);
        check("r_read_id_rd1", id_rd1, 16'hBEEF);
        tick();
        check("r_grant", dbg_grant, 1'b1);
        check("r_stall_off", stall, 1'b0);
        check("r_dbg_rd", dbg_rd, 16'hBEEF);
        check("r_scnt", stall_cycles, 16'd1);
        check("c_reissue_we", rf_we, 1'b1);
        check("c_reissue_a1", rf_a1, 4'd3);
        tick();
        wb_we = 1'b0; dbg_req = 1'b0; id_ra1 = 4'd3;
        #1;
        check("c_r3_final", id_rd1, 16'h00AA);
        tick();
        check("r_release", dbg_grant, 1'b0);

        // Withdraw in WAIT
        dbg_req = 1'b1; dbg_ra = 4'd1;
        tick();
        tick();
        check("w_wait_stall", stall, 1'b0);
        dbg_req = 1'b0;
        tick();
        tick();
        check("w_stall", stall, 1'b0);
        check("w_grant", dbg_grant, 1'b0);
        check("w_scnt", stall_cycles, 16'd1);

        // Reset in the middle of READ
        pipe_run = 1'b0; dbg_ra = 4'd5; dbg_req = 1'b1;
        tick();
        tick();
        check("m_read_stall", stall, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("m_stall", stall, 1'b0);
        check("m_grant", dbg_grant, 1'b0);
        check("m_dbg_rd", dbg_rd, 16'd0);
        check("m_scnt", stall_cycles, 16'd0);
        dbg_req = 1'b0; id_ra1 = 4'd2;
        tick();
        check("m_idle_a1", rf_a1, 4'd2);
        check("m_idle_grant", dbg_grant, 1'b0);

        // Back-to-back reads of R1 then R2 separated by one low cycle
        dbg_req = 1'b1; dbg_ra = 4'd1;
        tick(); tick(); tick();
        check("b1_grant", dbg_grant, 1'b1);
        check("b1_dbg_rd", dbg_rd, 16'h1111);
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_ra = 4'd2;
        tick(); tick(); tick();
        check("b2_grant", dbg_grant, 1'b1);
        check("b2_dbg_rd", dbg_rd, 16'h2222);
        check("b2_scnt", stall_cycles, 16'd2);
        dbg_req = 1'b0;
        tick();
        check("b2_release", dbg_grant, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
